// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the scan controller, its requester and the downstream 16:1 mux.
// The slave side is the controller; the master side issues requests and drives the mux output y.
interface mux_scan_ctrl_if;
  logic        start;
  logic        mode;
  logic [3:0]  ch;
  logic        y;
  logic [3:0]  sel;
  logic [15:0] data_out;
  logic        valid;
  logic        ready;
  logic        busy;

  modport master (
    output start, mode, ch, y, ready,
    input  sel, data_out, valid, busy
  );

  modport slave (
    input  start, mode, ch, y, ready,
    output sel, data_out, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a registered select across a 16:1 mux, waits SETTLE_CYCLES per channel,
// samples y into data_out and hands the word off with a valid/ready handshake.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam bit         NO_SETTLE = (SETTLE_CYCLES == 0);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          sel_d   = bus.mode ? bus.ch : 4'd0;
          data_d  = '0;
          cnt_d   = SETTLE_LD;
          state_d = NO_SETTLE ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        data_d[sel_q] = bus.y;
        // Full scans advance until channel 15; sel never wraps back to 0.
        if (!mode_q && (sel_q != 4'd15)) begin
          sel_d   = sel_q + 4'd1;
          cnt_d   = SETTLE_LD;
          state_d = NO_SETTLE ? SAMPLE : SETTLE;
        end else begin
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
  end

  assign bus.sel      = sel_q;
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, meaning: idle cycles after each sel change before sampling y; legal range 0..15.
REQ-002 Port clk  input  1  rising-edge clock, the only clock.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port start  input  1  scan request; sampled only in IDLE.
REQ-005 Port mode  input  1  0 = full scan of channels 0..15, 1 = single channel; sampled with start.
REQ-006 Port ch  input  4  channel for single mode; sampled with start.
REQ-007 Port y  input  1  output of the downstream 16:1 mux, driven by sel.
REQ-008 Port sel  output  4  registered select to the 16:1 mux.
REQ-009 Port data_out  output  16  captured word; bit i = y sampled with sel = i.
REQ-010 Port valid  output  1  data_out complete and stable.
REQ-011 Port ready  input  1  consumer accepts data_out.
REQ-012 Port busy  output  1  scan in progress.

Function
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-014 IDLE, start=1 at edge t0: latch mode; sel <= (mode ? ch : 0); data_out <= 0; settle counter <= SETTLE_CYCLES; go to SETTLE, or to SAMPLE if SETTLE_CYCLES = 0.
REQ-015 SETTLE: counter decrements each cycle; after exactly SETTLE_CYCLES cycles in SETTLE go to SAMPLE.
REQ-016 SAMPLE (one cycle): at its closing edge data_out[sel] <= y; other bits unchanged.
REQ-017 SAMPLE, full mode, sel != 15: sel <= sel+1, counter reloads, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES = 0).
REQ-018 SAMPLE, single mode or sel = 15: go to DONE, valid <= 1 at that same edge; no wrap of sel past 15.
REQ-019 Latency: valid rises at edge t0 + N*(SETTLE_CYCLES+1), N = 16 full, N = 1 single.
REQ-020 busy = 1 exactly in SETTLE and SAMPLE; 0 in IDLE and DONE.
REQ-021 DONE: valid held at 1; data_out and sel held stable until handshake.
REQ-022 Handshake completes at an edge with valid=1 and ready=1: valid <= 0, go to IDLE; data_out and sel retain values.
REQ-023 ready while valid=0 has no effect; ready may be held high continuously (DONE then lasts one cycle).
REQ-024 start outside IDLE, including the handshake-completion cycle, is ignored, not queued.
REQ-025 mode and ch changes after t0 have no effect on the running scan.
REQ-026 Single mode: data_out bits other than ch are 0 at valid.

Reset
REQ-027 rst_n = 0 forces immediately, independent of clk: state IDLE, sel = 0, data_out = 0, valid = 0, busy = 0, counter = 0.
REQ-028 Reset mid-scan or in DONE aborts; partial data discarded; no valid produced.
REQ-029 After rst_n deasserts, the first start is accepted at the first rising edge with start=1.

Verification
REQ-030 SETTLE_CYCLES=1, mux inputs d=16'hA5C3, full scan start -> sel steps 0..15 every 2 cycles, valid at t0+32, data_out = 16'hA5C3, busy low with valid.
REQ-031 SETTLE_CYCLES=1, mode=1, ch=9, d[9]=1 -> sel = 9, valid at t0+2, data_out = 16'h0200.
REQ-032 SETTLE_CYCLES=0, d=16'hFFFF, ready tied high -> valid at t0+16 for one cycle, data_out = 16'hFFFF, back in IDLE next cycle.
REQ-033 Full scan, ready low 10 cycles after valid, start pulsed and mode/d toggled during DONE -> valid held, data_out unchanged, no new scan; ready=1 -> IDLE.
REQ-034 rst_n low at sel = 7 mid-scan -> sel, data_out, valid, busy all 0 immediately; new start after release scans from channel 0 with correct data.
REQ-035 Two back-to-back full scans, d changed between them -> second data_out reflects new d only, no stale bits.
